// File: rtl/tmp_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tmp_regfile_pkg
//  Description : Shared types, width helpers and default sizes for the
//                temporary pointer register file and its sequential loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package tmp_regfile_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_BYTES  = 2;

   // Sequential loader states
   typedef enum logic [0:0] {
      SEQ_IDLE = 1'b0,
      SEQ_LOAD = 1'b1
   } seq_state_t;

   // Select width for n items, never narrower than one bit
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Byte-lane counter width for n lanes, never narrower than one bit
   function automatic int bcnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tmp_seq_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tmp_seq_loader
//  Description : Sequencer for multi-byte register loads. Latches the target
//                register on start, then walks byte lanes LSB first, one lane
//                per valid beat. Emits a capture strobe for the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmp_seq_loader
   import tmp_regfile_pkg::*;
#(
   parameter  int BYTES    = DEFAULT_BYTES,
   parameter  int NUM_REGS = 2,
   localparam int SEL_W    = sel_width(NUM_REGS),
   localparam int BSEL_W   = bcnt_width(BYTES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seq_start,
   input  logic              seq_valid,
   input  logic [SEL_W-1:0]  reg_sel,
   output logic              cap,
   output logic [SEL_W-1:0]  tgt,
   output logic [BSEL_W-1:0] lane,
   output logic              busy,
   output logic              seq_done
);

   localparam logic [BSEL_W-1:0] LAST_LANE = BSEL_W'(BYTES - 1);

   seq_state_t        state_q, state_d;
   logic [BSEL_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0]  tgt_q, tgt_d;
   logic              done_q, done_d;

   // Next-state logic: start latches the target, each valid beat advances a lane
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      done_d  = 1'b0;
      case (state_q)
         SEQ_IDLE: begin
            if (seq_start) begin
               tgt_d   = reg_sel;
               cnt_d   = '0;
               state_d = SEQ_LOAD;
            end
         end
         SEQ_LOAD: begin
            if (seq_valid) begin
               if (cnt_q == LAST_LANE) begin
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  state_d = SEQ_IDLE;
               end else begin
                  cnt_d = cnt_q + BSEL_W'(1);
               end
            end
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   // Sequencer state, counter, target and done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEQ_IDLE;
         cnt_q   <= '0;
         tgt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
         done_q  <= done_d;
      end
   end

   assign busy     = (state_q == SEQ_LOAD);
   assign cap      = busy & seq_valid;
   assign tgt      = tgt_q;
   assign lane     = cnt_q;
   assign seq_done = done_q;

endmodule
`default_nettype wire

// File: rtl/tmp_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tmp_regfile
//  Description : Parametrised temporary pointer register file. Byte-wise
//                loads from the data bus, sequential multi-byte loads,
//                increment/decrement with wrap flag, and combinational data
//                and address read-out with output-enable qualifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmp_regfile
   import tmp_regfile_pkg::*;
#(
   parameter  int DATA_W   = DEFAULT_DATA_W,
   parameter  int BYTES    = DEFAULT_BYTES,
   parameter  int NUM_REGS = 2,
   localparam int ADDR_W   = DATA_W * BYTES,
   localparam int SEL_W    = sel_width(NUM_REGS),
   localparam int BSEL_W   = bcnt_width(BYTES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SEL_W-1:0]  reg_sel,
   input  logic [BSEL_W-1:0] byte_sel,
   input  logic              load_byte,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   input  logic              addr_en,
   output logic [ADDR_W-1:0] addr_out,
   output logic              addr_oe,
   input  logic              inc,
   input  logic              dec,
   output logic              wrap,
   input  logic              seq_start,
   input  logic              seq_valid,
   output logic              busy,
   output logic              seq_done
);

   logic [ADDR_W-1:0] regs_q [NUM_REGS];
   logic [ADDR_W-1:0] regs_d [NUM_REGS];
   logic              wrap_q, wrap_d;

   logic              w_seq_cap;
   logic [SEL_W-1:0]  w_seq_tgt;
   logic [BSEL_W-1:0] w_seq_lane;
   logic              w_seq_busy;

   tmp_seq_loader #(
      .BYTES    (BYTES),
      .NUM_REGS (NUM_REGS)
   ) u_seq (
      .clk       (clk),
      .rst       (rst),
      .seq_start (seq_start),
      .seq_valid (seq_valid),
      .reg_sel   (reg_sel),
      .cap       (w_seq_cap),
      .tgt       (w_seq_tgt),
      .lane      (w_seq_lane),
      .busy      (w_seq_busy),
      .seq_done  (seq_done)
   );

   // Register update: sequence capture beats byte load beats inc/dec; host ops frozen while busy
   always_comb begin
      regs_d = regs_q;
      wrap_d = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (w_seq_cap) begin
            if (w_seq_tgt == SEL_W'(r)) begin
               for (int l = 0; l < BYTES; l++) begin
                  if (w_seq_lane == BSEL_W'(l)) begin
                     regs_d[r][l*DATA_W +: DATA_W] = data_in;
                  end
               end
            end
         end else if (!w_seq_busy && (reg_sel == SEL_W'(r))) begin
            if (load_byte) begin
               // Lanes beyond BYTES never match, so such writes fall away
               for (int l = 0; l < BYTES; l++) begin
                  if (byte_sel == BSEL_W'(l)) begin
                     regs_d[r][l*DATA_W +: DATA_W] = data_in;
                  end
               end
            end else if (inc && !dec) begin
               regs_d[r] = regs_q[r] + ADDR_W'(1);
               wrap_d    = (regs_q[r] == {ADDR_W{1'b1}});
            end else if (dec && !inc) begin
               regs_d[r] = regs_q[r] - ADDR_W'(1);
               wrap_d    = (regs_q[r] == '0);
            end
         end
      end
   end

   // Register array and wrap pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '{default: '0};
         wrap_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         wrap_q <= wrap_d;
      end
   end

   // Read-out mux: unselectable register numbers read back as zero
   always_comb begin
      addr_out = '0;
      data_out = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (reg_sel == SEL_W'(r)) begin
            addr_out = regs_q[r];
            for (int l = 0; l < BYTES; l++) begin
               if (byte_sel == BSEL_W'(l)) begin
                  data_out = regs_q[r][l*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   assign data_oe = rd_en & ~w_seq_busy;
   assign addr_oe = addr_en & ~w_seq_busy;
   assign busy    = w_seq_busy;
   assign wrap    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_tmp_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmp_regfile
//  Description : Self-checking bench for tmp_regfile at default parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tmp_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        reg_sel = 1'b0;
   logic        byte_sel = 1'b0;
   logic        load_byte = 1'b0;
   logic [7:0]  data_in = '0;
   logic        rd_en = 1'b0;
   logic [7:0]  data_out;
   logic        data_oe;
   logic        addr_en = 1'b0;
   logic [15:0] addr_out;
   logic        addr_oe;
   logic        inc = 1'b0;
   logic        dec = 1'b0;
   logic        wrap;
   logic        seq_start = 1'b0;
   logic        seq_valid = 1'b0;
   logic        busy;
   logic        seq_done;

   int checks = 0;
   int errors = 0;

   tmp_regfile dut (
      .clk       (clk),
      .rst       (rst),
      .reg_sel   (reg_sel),
      .byte_sel  (byte_sel),
      .load_byte (load_byte),
      .data_in   (data_in),
      .rd_en     (rd_en),
      .data_out  (data_out),
      .data_oe   (data_oe),
      .addr_en   (addr_en),
      .addr_out  (addr_out),
      .addr_oe   (addr_oe),
      .inc       (inc),
      .dec       (dec),
      .wrap      (wrap),
      .seq_start (seq_start),
      .seq_valid (seq_valid),
      .busy      (busy),
      .seq_done  (seq_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sel;
      logic        bsel;
      logic        ld;
      logic [7:0]  din;
      logic        inc;
      logic        dec;
      logic        rd;
      logic        ad;
      logic [15:0] e_addr;
      logic [7:0]  e_data;
      logic        e_wrap;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic sel, input logic bsel, input logic ld,
                               input logic [7:0] din, input logic i, input logic d,
                               input logic rd, input logic ad, input logic [15:0] ea,
                               input logic [7:0] ed, input logic ew);
      vec_t v;
      v.sel = sel; v.bsel = bsel; v.ld = ld; v.din = din; v.inc = i; v.dec = d;
      v.rd = rd; v.ad = ad; v.e_addr = ea; v.e_data = ed; v.e_wrap = ew;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // sel bsel ld din inc dec rd ad | addr data wrap
      vecs[0]  = mk(1, 0, 1, 8'h34, 0, 0, 1, 1, 16'h0034, 8'h34, 0);
      vecs[1]  = mk(1, 1, 1, 8'h12, 0, 0, 1, 0, 16'h1234, 8'h12, 0);
      vecs[2]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 16'h0000, 8'h00, 0);
      vecs[3]  = mk(0, 0, 1, 8'hFF, 0, 0, 0, 0, 16'h00FF, 8'hFF, 0);
      vecs[4]  = mk(0, 1, 0, 8'h00, 1, 0, 1, 1, 16'h0100, 8'h01, 0);
      vecs[5]  = mk(0, 1, 1, 8'hFF, 0, 0, 1, 1, 16'hFF00, 8'hFF, 0);
      vecs[6]  = mk(0, 0, 1, 8'hFF, 0, 0, 1, 1, 16'hFFFF, 8'hFF, 0);
      vecs[7]  = mk(0, 0, 0, 8'h00, 1, 0, 1, 1, 16'h0000, 8'h00, 1);
      vecs[8]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 1, 16'h0000, 8'h00, 0);
      vecs[9]  = mk(0, 1, 0, 8'h00, 0, 1, 1, 1, 16'hFFFF, 8'hFF, 1);
      vecs[10] = mk(0, 0, 0, 8'h00, 1, 1, 1, 1, 16'hFFFF, 8'hFF, 0);
      vecs[11] = mk(0, 0, 0, 8'h00, 0, 1, 1, 1, 16'hFFFE, 8'hFE, 0);
      vecs[12] = mk(1, 0, 0, 8'h00, 0, 0, 1, 1, 16'h1234, 8'h34, 0);
      vecs[13] = mk(1, 0, 1, 8'h55, 1, 0, 1, 1, 16'h1255, 8'h55, 0);
      vecs[14] = mk(0, 1, 0, 8'h00, 0, 1, 1, 1, 16'hFFFD, 8'hFF, 0);

      // Asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_addr", 32'(addr_out), 32'h0000);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(seq_done), 32'h0);
      chk("rst_wrap", 32'(wrap), 32'h0);
      addr_en = 1'b1;
      #1;
      chk("rst_addr_oe", 32'(addr_oe), 32'h1);
      addr_en = 1'b0;
      #3 rst = 1'b0;

      // Table-driven single-cycle operations
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         reg_sel = vecs[i].sel; byte_sel = vecs[i].bsel; load_byte = vecs[i].ld;
         data_in = vecs[i].din; inc = vecs[i].inc; dec = vecs[i].dec;
         rd_en = vecs[i].rd; addr_en = vecs[i].ad;
         step();
         chk($sformatf("v%0d_addr", i), 32'(addr_out), 32'(vecs[i].e_addr));
         chk($sformatf("v%0d_data", i), 32'(data_out), 32'(vecs[i].e_data));
         chk($sformatf("v%0d_wrap", i), 32'(wrap), 32'(vecs[i].e_wrap));
         chk($sformatf("v%0d_data_oe", i), 32'(data_oe), 32'(vecs[i].rd));
         chk($sformatf("v%0d_addr_oe", i), 32'(addr_oe), 32'(vecs[i].ad));
      end
      load_byte = 1'b0; inc = 1'b0; dec = 1'b0;
      // reg0 = 0xFFFD, reg1 = 0x1255

      // Sequential load with gaps; valid alongside start is not captured
      reg_sel = 1'b1; byte_sel = 1'b0; rd_en = 1'b1; addr_en = 1'b1;
      seq_start = 1'b1; seq_valid = 1'b1; data_in = 8'h99;
      step();
      chk("seq_busy0", 32'(busy), 32'h1);
      chk("seq_nocap", 32'(addr_out), 32'h1255);
      chk("seq_data_oe", 32'(data_oe), 32'h0);
      chk("seq_addr_oe", 32'(addr_oe), 32'h0);
      seq_start = 1'b0; data_in = 8'hCD;
      step();
      chk("seq_partial", 32'(addr_out), 32'h12CD);
      chk("seq_busy1", 32'(busy), 32'h1);
      seq_valid = 1'b0;

      // Host ops while busy must have no effect
      reg_sel = 1'b0; load_byte = 1'b1; inc = 1'b1; seq_start = 1'b1; data_in = 8'h77;
      #1;
      chk("busy_data_oe", 32'(data_oe), 32'h0);
      chk("busy_addr_oe", 32'(addr_oe), 32'h0);
      step();
      chk("busy_reg0_a", 32'(addr_out), 32'hFFFD);
      chk("busy_wrap", 32'(wrap), 32'h0);
      chk("seq_busy2", 32'(busy), 32'h1);
      step();
      chk("busy_reg0_b", 32'(addr_out), 32'hFFFD);
      chk("seq_busy3", 32'(busy), 32'h1);
      load_byte = 1'b0; inc = 1'b0; seq_start = 1'b0;
      reg_sel = 1'b1; seq_valid = 1'b1; data_in = 8'hAB;
      step();
      chk("seq_final", 32'(addr_out), 32'hABCD);
      chk("seq_busy_end", 32'(busy), 32'h0);
      chk("seq_done_hi", 32'(seq_done), 32'h1);
      chk("seq_data_out", 32'(data_out), 32'hCD);
      chk("seq_data_oe_back", 32'(data_oe), 32'h1);
      seq_valid = 1'b0;
      step();
      chk("seq_done_lo", 32'(seq_done), 32'h0);
      chk("seq_hold", 32'(addr_out), 32'hABCD);

      // Reset in the middle of a sequence
      seq_start = 1'b1;
      step();
      seq_start = 1'b0; seq_valid = 1'b1; data_in = 8'h5A;
      step();
      chk("abort_partial", 32'(addr_out), 32'hAB5A);
      seq_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("abort_reg1", 32'(addr_out), 32'h0000);
      chk("abort_busy", 32'(busy), 32'h0);
      reg_sel = 1'b0;
      #0.1;
      chk("abort_reg0", 32'(addr_out), 32'h0000);
      #0.9 rst = 1'b0;
      reg_sel = 1'b1;
      step();
      chk("abort_idle", 32'(busy), 32'h0);

      // Fresh sequence after reset
      seq_start = 1'b1;
      step();
      seq_start = 1'b0; seq_valid = 1'b1; data_in = 8'h11;
      step();
      data_in = 8'h22;
      step();
      seq_valid = 1'b0;
      chk("fresh_val", 32'(addr_out), 32'h2211);
      chk("fresh_done", 32'(seq_done), 32'h1);
      chk("fresh_busy", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
